// File: rtl/wbh_reg_arb.sv
// Round-robin arbiter sharing the wb_host register bus between the Wishbone host
// (requester 0) and the debug master (requester 1), with a slave-ack timeout.
module wbh_reg_arb #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic        mclk,
    input  logic        p_reset_n,
    input  logic        req0_cs,
    input  logic        req0_wr,
    input  logic [2:0]  req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_be,
    output logic [31:0] req0_rdata,
    output logic        req0_ack,
    output logic        req0_err,
    input  logic        req1_cs,
    input  logic        req1_wr,
    input  logic [2:0]  req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_be,
    output logic [31:0] req1_rdata,
    output logic        req1_ack,
    output logic        req1_err,
    output logic        reg_cs,
    output logic        reg_wr,
    output logic [2:0]  reg_addr,
    output logic [31:0] reg_wdata,
    output logic [3:0]  reg_be,
    input  logic [31:0] reg_rdata,
    input  logic        reg_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic        wr_q, wr_d;
    logic [2:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        grant;

    logic [1:0]        req_cs;
    logic [1:0]        req_wr;
    logic [1:0][2:0]   req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0][3:0]   req_be;
    logic [1:0]        ack;
    logic [1:0][31:0]  rdata;

    assign req_cs    = {req1_cs, req0_cs};
    assign req_wr    = {req1_wr, req0_wr};
    assign req_addr  = {req1_addr, req0_addr};
    assign req_wdata = {req1_wdata, req0_wdata};
    assign req_be    = {req1_be, req0_be};

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        grant        = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_cs) begin
                    // On a tie the requester that did not go last wins.
                    grant   = (req_cs == 2'b11) ? ~last_owner_q : req_cs[1];
                    owner_d = grant;
                    wr_d    = req_wr[grant];
                    addr_d  = req_addr[grant];
                    wdata_d = req_wdata[grant];
                    be_d    = req_be[grant];
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (reg_ack) begin
                    err_d        = 1'b0;
                    last_owner_d = owner_q;
                    state_d      = DONE;
                end else if (cnt_q == TO_LAST) begin
                    err_d        = 1'b1;
                    last_owner_d = owner_q;
                    state_d      = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge p_reset_n) begin
        if (!p_reset_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            wr_q         <= 1'b0;
            addr_q       <= 3'd0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            cnt_q        <= 8'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            logic        mine;
            logic [31:0] rdata_q, rdata_d;

            assign mine = (owner_q == 1'(gi));

            // Read data is captured on slave ack; a timeout forces it to zero.
            always_comb begin
                rdata_d = rdata_q;
                if (state_q == BUSY && mine) begin
                    if (reg_ack) begin
                        if (!wr_q) rdata_d = reg_rdata;
                    end else if (cnt_q == TO_LAST) begin
                        rdata_d = 32'd0;
                    end
                end
            end

            always_ff @(posedge mclk or negedge p_reset_n) begin
                if (!p_reset_n) rdata_q <= 32'd0;
                else            rdata_q <= rdata_d;
            end

            assign ack[gi]   = (state_q == DONE) && mine;
            assign rdata[gi] = rdata_q;
        end
    endgenerate

    assign req0_ack   = ack[0];
    assign req1_ack   = ack[1];
    assign req0_err   = ack[0] & err_q;
    assign req1_err   = ack[1] & err_q;
    assign req0_rdata = rdata[0];
    assign req1_rdata = rdata[1];

    assign reg_cs    = (state_q == BUSY);
    assign reg_wr    = wr_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_be    = be_q;

endmodule
